// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave memory: pipelined address/data phases, fixed wait states,
// byte-lane writes by Hsize and a two-cycle ERROR response for illegal transfers.
module ahb_slave_mem #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  Hsel,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic [1:0]            Htrans,
    input  logic                  Hwrite,
    input  logic [2:0]            Hsize,
    input  logic [2:0]            Hburst,
    input  logic [3:0]            Hprot,
    input  logic                  Hmastlock,
    input  logic [DATA_WIDTH-1:0] Hwdata,
    input  logic                  Hready_in,
    output logic [DATA_WIDTH-1:0] Hrdata,
    output logic                  Hready_out,
    output logic                  Hresp
);

    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned LB = $clog2(NB);
    localparam int unsigned IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CW = 4;
    localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(NB);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ERR1, S_ERR2} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [LB-1:0]           lane_q, lane_d;
    logic [2:0]              size_q, size_d;
    logic                    write_q, write_d;
    logic                    hready_d, hresp_d;
    logic [DATA_WIDTH-1:0]   hrdata_d;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic                    free_c, accept_c, legal_c, wr_en_c;
    logic [LB-1:0]           amask_c;
    logic [NB-1:0]           be_c;
    logic [DATA_WIDTH-1:0]   wr_word_c, rd_word_c;
    logic                    unused_c;

    assign unused_c = ^{Hburst, Hprot, Hmastlock};

    // Address-phase qualification and legality of the offered transfer
    always_comb begin
        amask_c  = LB'((32'd1 << Hsize) - 32'd1);
        legal_c  = (64'(Haddr) < MEM_BYTES) && (Hsize <= 3'(LB))
                   && ((Haddr[LB-1:0] & amask_c) == '0);
        free_c   = (state_q == S_IDLE) || (state_q == S_ERR2)
                   || ((state_q == S_ACCESS) && (cnt_q == '0));
        accept_c = Hsel & Hready_in & Htrans[1] & free_c;
        wr_en_c  = (state_q == S_ACCESS) && (cnt_q == '0) && write_q;
    end

    // Byte-lane merge of the completing write into the addressed word
    always_comb begin
        be_c = NB'(((32'd1 << (32'd1 << size_q)) - 32'd1) << lane_q);
        for (int unsigned b = 0; b < NB; b++) begin
            wr_word_c[8*b +: 8] = be_c[b] ? Hwdata[8*b +: 8] : mem[idx_q][8*b +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            S_ACCESS: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            S_ERR1:   state_d = S_ERR2;
            default:  ;
        endcase
        if (free_c) begin
            state_d = S_IDLE;
            if (accept_c) begin
                idx_d   = Haddr[LB +: IW];
                lane_d  = Haddr[LB-1:0];
                size_d  = Hsize;
                write_d = Hwrite;
                if (legal_c) begin
                    state_d = S_ACCESS;
                    cnt_d   = CW'(WAIT_STATES);
                end else begin
                    state_d = S_ERR1;
                end
            end
        end

        // Outputs are registered, so they are derived from the next state;
        // a write retiring on the same edge is forwarded to a following read.
        hready_d  = (state_d != S_ERR1) && !((state_d == S_ACCESS) && (cnt_d != '0));
        hresp_d   = (state_d == S_ERR1) || (state_d == S_ERR2);
        rd_word_c = (wr_en_c && (idx_d == idx_q)) ? wr_word_c : mem[idx_d];
        hrdata_d  = ((state_d == S_ACCESS) && (cnt_d == '0) && !write_d) ? rd_word_c : '0;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            lane_q     <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            Hready_out <= 1'b1;
            Hresp      <= 1'b0;
            Hrdata     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            lane_q     <= lane_d;
            size_q     <= size_d;
            write_q    <= write_d;
            Hready_out <= hready_d;
            Hresp      <= hresp_d;
            Hrdata     <= hrdata_d;
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge hclk) begin
        if (wr_en_c) mem[idx_q] <= wr_word_c;
    end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
- Parametrised AHB-Lite slave memory responder that sits on the same pin-level bus as the AHB_UVC VIP.
- Serves as the default DUT/reference slave in the UVC testbench.
- Adds behaviour the bare bus bundle lacks:
  - pipelined address/data phases
  - programmable wait states
  - byte-lane writes per Hsize
  - two-cycle ERROR response for illegal transfers
- Data width, address width and memory depth are generalised by parameter.

Parameters:
- ADDR_WIDTH, 32: Haddr width.
- DATA_WIDTH, 32: Hwdata/Hrdata width. Legal values are 32 and 64.
- MEM_DEPTH, 1024: number of DATA_WIDTH-bit words. The byte range is 0 to MEM_DEPTH*DATA_WIDTH/8 - 1.
- WAIT_STATES, 0: wait cycles inserted in every OKAY data phase. Range 0..15.

Ports:
- hclk  in  1  bus clock; all state updates on its rising edge.
- hresetn  in  1  asynchronous active-low reset.
- Hsel  in  1  slave select.
- Haddr  in  ADDR_WIDTH  transfer address.
- Htrans  in  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ.
- Hwrite  in  1  1=write.
- Hsize  in  3  log2 of bytes per beat.
- Hburst  in  3  burst type; ignored functionally.
- Hprot  in  4  protection; ignored.
- Hmastlock  in  1  locked transfer; ignored.
- Hwdata  in  DATA_WIDTH  write data, valid in the data phase.
- Hready_in  in  1  bus-level HREADY; qualifies the address phase.
- Hrdata  out  DATA_WIDTH  read data.
- Hready_out  out  1  slave ready.
- Hresp  out  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (asynchronous, hresetn low):
  - state=IDLE, Hready_out=1, Hresp=0, Hrdata=0, wait counter=0.
  - Any latched address phase is discarded; a pending write is never performed.
  - Memory contents are not reset.
- Accept condition: Hsel & Hready_in & Htrans[1] at a rising edge. On accept, latch Haddr, Hwrite and Hsize.
  - IDLE or BUSY transfers, or Hsel=0, are not accepted; the slave stays/returns to IDLE with a zero-wait OKAY.
- Legality check at accept. A transfer is illegal if any of these hold:
  - address out of range (Haddr >= MEM_DEPTH*DATA_WIDTH/8);
  - Hsize > log2(DATA_WIDTH/8);
  - Haddr not aligned to 2^Hsize.
  - Illegal -> ERR1. Legal -> ACCESS, with wait counter loaded to WAIT_STATES.
- States and outputs:
  - IDLE: Hready_out=1, Hresp=0.
  - ACCESS: Hready_out=(cnt==0), Hresp=0. cnt decrements each cycle while nonzero. The cycle with cnt==0 is the completing cycle.
  - ERR1: Hready_out=0, Hresp=1. Always lasts one cycle, regardless of WAIT_STATES, then -> ERR2.
  - ERR2: Hready_out=1, Hresp=1. No memory access occurs for an erroring transfer.
- Completing cycle of ACCESS or ERR2:
  - A new accept may occur in the same cycle (back-to-back pipelining). Next state follows the legality check.
  - With no new accept, next state is IDLE.
- Writes:
  - Performed at the rising edge ending the completing cycle, using Hwdata.
  - Only the byte lanes selected by Haddr[log2(DATA_WIDTH/8)-1:0] and Hsize are written (little-endian lane mapping). Other bytes are unchanged.
- Reads:
  - Hrdata = full word at the latched word address during the completing cycle. Unselected lanes also carry the word's data.
  - Hrdata = 0 in all other cycles.
  - Read-after-write to the same address issued back-to-back returns the newly written data.
- Bursts: every beat is treated as an independent transfer using the address on the bus. A BUSY inside a burst gives a zero-wait OKAY.
- Hready_in=0 while Hsel=1 (another slave stalling): no accept; this slave's own state still advances.
- Width/wrap: word index = Haddr >> log2(DATA_WIDTH/8). No address wrap; out-of-range always errors.

Test Plan:
- WAIT_STATES=0, DATA_WIDTH=32: NONSEQ write 0xDEADBEEF @0x10, then NONSEQ read @0x10 back-to-back -> write completes with Hready_out=1 and no stall; read data phase returns Hrdata=0xDEADBEEF, Hresp=0.
- WAIT_STATES=3: single read @0x0 -> Hready_out low for exactly 3 cycles, high on the 4th with data; Hresp=0 throughout.
- Byte writes: write 0x11223344 @0x20, then Hsize=0 write Hwdata=0x00AA0000 @0x22 -> read @0x20 returns 0x11AA3344.
- Error: read @MEM_DEPTH*4 -> one cycle Hready_out=0/Hresp=1, then one cycle Hready_out=1/Hresp=1. Unaligned halfword write @0x21 -> same 2-cycle ERROR and memory unchanged.
- IDLE/BUSY transfers and Hsel=0 -> Hready_out=1, Hresp=0, no memory change. INCR4 burst with a BUSY beat -> 4 correct words written.
- Assert hresetn mid-ACCESS of a write with WAIT_STATES=2 -> outputs immediately Hready_out=1, Hresp=0, Hrdata=0; target word unchanged.
